// File: rtl/answer_pkg.sv
// answer_pkg: shared state encoding and 7-segment tables for the answer-window timer.
package answer_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_DASH  = 8'hBF;
    localparam logic [7:0] SEG_DIGIT [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                              8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [7:0] int_to_seg(input logic [3:0] d);
        return (d <= 4'd9) ? SEG_DIGIT[d] : SEG_BLANK;
    endfunction

endpackage

// File: rtl/bcd_seg_encoder.sv
// bcd_seg_encoder: value -> {tens,units} active-low 7-seg bytes; values above 99 show two dashes.
module bcd_seg_encoder
    import answer_pkg::*;
#(
    parameter int IN_W = 8
) (
    input  logic [IN_W-1:0] value,
    output logic [15:0]     seg
);

    // Widen narrow inputs so the 99 limit and the divisor fit the arithmetic width.
    localparam int W = (IN_W > 7) ? IN_W : 7;

    logic [W-1:0] v;
    logic [3:0]   tens;
    logic [3:0]   units;

    always_comb begin
        v     = W'(value);
        tens  = 4'(v / W'(10));
        units = 4'(v % W'(10));
        seg   = (v > W'(99)) ? {SEG_DASH, SEG_DASH} : {int_to_seg(tens), int_to_seg(units)};
    end

endmodule

// File: rtl/answer_period_timer.sv
// answer_period_timer: PERIOD_SEC-second answer window with live/frozen per-channel count display.
// Optional countdown display on TimeSeg when ANSWER_COUNTDOWN_SEG_EN is defined.
module answer_period_timer
    import answer_pkg::*;
#(
    parameter int PERIOD_SEC = 5,
    parameter int NUM_CH     = 2,
    parameter int CNT_W      = 8,
    parameter int TIME_W     = 7
) (
    input  logic                    Clk100M,
    input  logic                    Rst,
    input  logic                    Tick1Hz,
    input  logic                    AnswerSig,
    input  logic                    Abort,
    input  logic [NUM_CH*CNT_W-1:0] UserCount,
    output logic                    Busy,
    output logic                    PostSig,
    output logic                    StopCount,
    output logic [TIME_W-1:0]       TimeLeft,
    output logic [NUM_CH*16-1:0]    CountSeg,
    output logic [15:0]             TimeSeg
);

    state_t                 state;
    state_t                 state_nx;
    logic [TIME_W-1:0]      tl_nx;
    logic                   frozen;
    logic [NUM_CH*16-1:0]   count_enc;

    always_ff @(posedge Clk100M) begin
        state <= Rst ? IDLE : state_nx;
    end

    always_comb begin
        state_nx = state;
        tl_nx    = TimeLeft;
        case (state)
            IDLE: if (AnswerSig) begin
                state_nx = RUN;
                tl_nx    = TIME_W'(PERIOD_SEC);
            end
            RUN: if (Abort) begin
                state_nx = IDLE;
                tl_nx    = '0;
            end else if (Tick1Hz) begin
                tl_nx    = TimeLeft - TIME_W'(1);
                state_nx = (TimeLeft == TIME_W'(1)) ? DONE : RUN;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        Busy      = (state == RUN);
        PostSig   = (state == DONE);
        StopCount = (state == DONE);
    end

    // The seg register itself is the snapshot: its last load happens on the DONE cycle.
    always_ff @(posedge Clk100M) begin
        if (Rst) begin
            TimeLeft <= '0;
            frozen   <= 1'b0;
            CountSeg <= '1;
        end else begin
            TimeLeft <= tl_nx;
            frozen   <= (state == IDLE && AnswerSig) ? 1'b0 : (state == DONE) ? 1'b1 : frozen;
            if (!frozen) CountSeg <= count_enc;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        bcd_seg_encoder #(.IN_W(CNT_W)) u_enc (
            .value(UserCount[g*CNT_W +: CNT_W]),
            .seg  (count_enc[g*16 +: 16])
        );
    end

`ifdef ANSWER_COUNTDOWN_SEG_EN
    logic [15:0] time_enc;

    bcd_seg_encoder #(.IN_W(TIME_W)) u_time_enc (
        .value(tl_nx),
        .seg  (time_enc)
    );

    always_ff @(posedge Clk100M) begin
        TimeSeg <= (Rst || state_nx != RUN) ? 16'hFFFF : time_enc;
    end
`else
    assign TimeSeg = 16'hFFFF;
`endif

endmodule

// File: tb/tb_answer_period_timer.sv
// tb_answer_period_timer: directed + random stimulus, window-level reference model, queued scoreboard.
module tb_answer_period_timer;

    localparam int P = 5;

    logic        Clk100M = 1'b0;
    logic        Rst = 1'b1;
    logic        Tick1Hz = 1'b0;
    logic        AnswerSig = 1'b0;
    logic        Abort = 1'b0;
    logic [15:0] UserCount = '0;
    logic        Busy;
    logic        PostSig;
    logic        StopCount;
    logic [6:0]  TimeLeft;
    logic [31:0] CountSeg;
    logic [15:0] TimeSeg;

    answer_period_timer #(.PERIOD_SEC(P), .NUM_CH(2), .CNT_W(8), .TIME_W(7)) dut (
        .Clk100M  (Clk100M),
        .Rst      (Rst),
        .Tick1Hz  (Tick1Hz),
        .AnswerSig(AnswerSig),
        .Abort    (Abort),
        .UserCount(UserCount),
        .Busy     (Busy),
        .PostSig  (PostSig),
        .StopCount(StopCount),
        .TimeLeft (TimeLeft),
        .CountSeg (CountSeg),
        .TimeSeg  (TimeSeg)
    );

    always #5 Clk100M = ~Clk100M;

    typedef struct {
        logic        busy;
        logic        post;
        logic [6:0]  tl;
        logic [31:0] cseg;
        logic [15:0] tseg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   dut_posts = 0;
    int   exp_posts = 0;

    logic [7:0] segtab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

    function automatic logic [15:0] enc(int v);
        if (v < 0) return 16'hFFFF;
        if (v > 99) return 16'hBFBF;
        return {segtab[v / 10], segtab[v % 10]};
    endfunction

    // Reference model: a window is "running" for P ticks, then one post cycle; display values are ints.
    bit running = 0;
    bit post_pend = 0;
    bit frozen = 0;
    int rem = 0;
    int disp [2] = '{-1, -1};

    always @(posedge Clk100M) begin
        exp_t e;
        if (Rst) begin
            running = 0; post_pend = 0; frozen = 0; rem = 0;
            disp = '{-1, -1};
        end else begin
            for (int c = 0; c < 2; c++)
                if (!frozen) disp[c] = int'(UserCount[c*8 +: 8]);
            if (post_pend) begin
                post_pend = 0;
                frozen = 1;
            end else if (!running) begin
                if (AnswerSig) begin running = 1; rem = P; frozen = 0; end
            end else if (Abort) begin
                running = 0; rem = 0;
            end else if (Tick1Hz) begin
                rem = rem - 1;
                if (rem == 0) begin running = 0; post_pend = 1; end
            end
        end
        e.busy = running;
        e.post = post_pend;
        e.tl   = 7'(rem);
        e.cseg = {enc(disp[1]), enc(disp[0])};
`ifdef ANSWER_COUNTDOWN_SEG_EN
        e.tseg = running ? enc(rem) : 16'hFFFF;
`else
        e.tseg = 16'hFFFF;
`endif
        q.push_back(e);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge Clk100M) begin
        exp_t e;
        if (q.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_empty at %0t", $time);
        end else begin
            e = q.pop_front();
            chk("Busy", 32'(Busy), 32'(e.busy));
            chk("PostSig", 32'(PostSig), 32'(e.post));
            chk("StopCount", 32'(StopCount), 32'(e.post));
            chk("TimeLeft", 32'(TimeLeft), 32'(e.tl));
            chk("CountSeg", CountSeg, e.cseg);
            chk("TimeSeg", 32'(TimeSeg), 32'(e.tseg));
            dut_posts += int'(PostSig);
            exp_posts += int'(e.post);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk100M);
    endtask

    task automatic tick();
        cyc(2);
        Tick1Hz = 1'b1;
        cyc(1);
        Tick1Hz = 1'b0;
    endtask

    initial begin
        cyc(3);
        Rst = 1'b0;
        UserCount = {8'd0, 8'd37};
        cyc(2);
        AnswerSig = 1'b1;
        Tick1Hz = 1'b1;
        cyc(1);
        AnswerSig = 1'b0;
        Tick1Hz = 1'b0;
        repeat (P) tick();
        cyc(1);
        UserCount = {8'd0, 8'd12};
        cyc(4);
        UserCount = {8'd150, 8'd12};
        cyc(3);
        AnswerSig = 1'b1;
        cyc(1);
        AnswerSig = 1'b0;
        cyc(3);
        tick();
        tick();
        Abort = 1'b1;
        Tick1Hz = 1'b1;
        cyc(1);
        Abort = 1'b0;
        Tick1Hz = 1'b0;
        cyc(3);
        UserCount = {8'd0, 8'd99};
        AnswerSig = 1'b1;
        repeat (P + 1) tick();
        cyc(2);
        AnswerSig = 1'b0;
        repeat (P) tick();
        cyc(3);
        AnswerSig = 1'b1;
        cyc(1);
        AnswerSig = 1'b0;
        tick();
        tick();
        Rst = 1'b1;
        cyc(1);
        Rst = 1'b0;
        cyc(3);
        for (int i = 0; i < 5000; i++) begin
            Tick1Hz   = ($urandom_range(3) == 0);
            AnswerSig = ($urandom_range(7) == 0);
            Abort     = ($urandom_range(40) == 0);
            Rst       = ($urandom_range(400) == 0);
            if ($urandom_range(9) == 0)
                UserCount = {8'($urandom_range(255)), 8'($urandom_range(120))};
            cyc(1);
        end
        Rst = 1'b0;
        Tick1Hz = 1'b0;
        AnswerSig = 1'b0;
        Abort = 1'b0;
        cyc(3);
        @(posedge Clk100M);
        chk("post_count", 32'(dut_posts), 32'(exp_posts));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
